// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the SRAM / memory-mapped I/O access controller.
// Holds the FSM state encoding, the default I/O address and the wait-counter width helper.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

   // Width of a counter that must hold values 0..wait_cycles.
   function automatic int cnt_width(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/tri_buffer_16.sv
// 16-bit tristate driver: passes In onto Out when Enable is high, otherwise releases the bus.
module tri_buffer_16 (
   input  logic        Enable,
   input  logic [15:0] In,
   output wire  [15:0] Out
);

   assign Out = Enable ? In : 16'hzzzz;

endmodule

// File: rtl/mem_access_ctrl.sv
// Single-request SRAM access sequencer (IDLE/SETUP/ACCESS/DONE) with a memory-mapped
// I/O window: reads of IO_ADDR return Switches, writes to IO_ADDR load Hex_data.
module mem_access_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          WAIT_CYCLES = 2,
   parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Req,
   input  logic        Wr,
   input  logic [15:0] Addr,
   input  logic [15:0] Wdata,
   input  logic [15:0] Switches,
   output logic [15:0] Rdata,
   output logic        Done,
   output logic        Busy,
   output logic [15:0] Hex_data,
   output logic [15:0] ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        CE,
   output logic        UB,
   output logic        LB,
   output logic        OE,
   output logic        WE
);

   localparam int            CW       = cnt_width(WAIT_CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t        state_r,   state_nxt_s;
   logic [CW-1:0] cnt_r,     cnt_nxt_s;
   logic [15:0]   addr_r,    addr_nxt_s;
   logic [15:0]   wdata_r,   wdata_nxt_s;
   logic          wr_r,      wr_nxt_s;
   logic          io_r,      io_nxt_s;
   logic [15:0]   rdata_r,   rdata_nxt_s;
   logic [15:0]   hex_r,     hex_nxt_s;
   logic          done_r,    done_nxt_s;
   logic          busy_r,    busy_nxt_s;
   logic          ce_r,      ce_nxt_s;
   logic          oe_r,      oe_nxt_s;
   logic          we_r,      we_nxt_s;
   logic          dq_en_r,   dq_en_nxt_s;
   logic          sram_act_s;

   // Next-state, data-capture and next-strobe decode; strobes derive from the next state so they register cleanly.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      addr_nxt_s  = addr_r;
      wdata_nxt_s = wdata_r;
      wr_nxt_s    = wr_r;
      io_nxt_s    = io_r;
      rdata_nxt_s = rdata_r;
      hex_nxt_s   = hex_r;

      case (state_r)
         ST_IDLE: begin
            if (Req) begin
               state_nxt_s = ST_SETUP;
               addr_nxt_s  = Addr;
               wdata_nxt_s = Wdata;
               wr_nxt_s    = Wr;
               io_nxt_s    = (Addr == IO_ADDR);
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_SETUP: begin
            state_nxt_s = ST_ACCESS;
            cnt_nxt_s   = CNT_LOAD;
         end
         ST_ACCESS: begin
            if (cnt_r == CNT_ZERO) begin
               state_nxt_s = ST_DONE;
               // Read data is sampled on the edge leaving ACCESS, after the full strobe window.
               if (!wr_r) begin
                  if (io_r) begin
                     rdata_nxt_s = Switches;
                  end else begin
                     rdata_nxt_s = SRAM_DQ;
                  end
               end else if (io_r) begin
                  hex_nxt_s = wdata_r;
               end else begin
                  hex_nxt_s = hex_r;
               end
            end else begin
               cnt_nxt_s = cnt_r - CNT_ONE;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase

      sram_act_s  = ((state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS)) && !io_nxt_s;
      ce_nxt_s    = !sram_act_s;
      oe_nxt_s    = !(sram_act_s && !wr_nxt_s);
      we_nxt_s    = !(sram_act_s && wr_nxt_s && (state_nxt_s == ST_ACCESS));
      dq_en_nxt_s = !we_nxt_s;
      done_nxt_s  = (state_nxt_s == ST_DONE);
      busy_nxt_s  = (state_nxt_s != ST_IDLE);
   end

   // State, latched request and registered outputs; reset aborts any transaction with strobes released.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         addr_r  <= 16'h0000;
         wdata_r <= 16'h0000;
         wr_r    <= 1'b0;
         io_r    <= 1'b0;
         rdata_r <= 16'h0000;
         hex_r   <= 16'h0000;
         done_r  <= 1'b0;
         busy_r  <= 1'b0;
         ce_r    <= 1'b1;
         oe_r    <= 1'b1;
         we_r    <= 1'b1;
         dq_en_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         addr_r  <= addr_nxt_s;
         wdata_r <= wdata_nxt_s;
         wr_r    <= wr_nxt_s;
         io_r    <= io_nxt_s;
         rdata_r <= rdata_nxt_s;
         hex_r   <= hex_nxt_s;
         done_r  <= done_nxt_s;
         busy_r  <= busy_nxt_s;
         ce_r    <= ce_nxt_s;
         oe_r    <= oe_nxt_s;
         we_r    <= we_nxt_s;
         dq_en_r <= dq_en_nxt_s;
      end
   end

   tri_buffer_16 u_dq_buf (
      .Enable (dq_en_r),
      .In     (wdata_r),
      .Out    (SRAM_DQ)
   );

   assign Rdata    = rdata_r;
   assign Done     = done_r;
   assign Busy     = busy_r;
   assign Hex_data = hex_r;
   assign ADDR     = addr_r;
   assign CE       = ce_r;
   assign UB       = ce_r;
   assign LB       = ce_r;
   assign OE       = oe_r;
   assign WE       = we_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: a WAIT_CYCLES=2 instance against a behavioural SRAM,
// plus a WAIT_CYCLES=1 instance against a fixed-pattern read-only SRAM.
module tb_mem_access_ctrl;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        req, wr;
   logic [15:0] addr, wdata, switches;
   logic [15:0] rdata, hex_data, sram_addr;
   logic        done, busy, ce, ub, lb, oe, we;
   tri1  [15:0] sram_dq;

   logic        req1, wr1;
   logic [15:0] addr1, wdata1, switches1;
   logic [15:0] rdata1, hex_data1, sram_addr1;
   logic        done1, busy1, ce1, ub1, lb1, oe1, we1;
   tri1  [15:0] sram_dq1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 Clk = ~Clk;

   mem_access_ctrl #(.WAIT_CYCLES(2)) dut (
      .Clk(Clk), .Reset(Reset), .Req(req), .Wr(wr), .Addr(addr), .Wdata(wdata),
      .Switches(switches), .Rdata(rdata), .Done(done), .Busy(busy), .Hex_data(hex_data),
      .ADDR(sram_addr), .SRAM_DQ(sram_dq), .CE(ce), .UB(ub), .LB(lb), .OE(oe), .WE(we)
   );

   mem_access_ctrl #(.WAIT_CYCLES(1)) dut1 (
      .Clk(Clk), .Reset(Reset), .Req(req1), .Wr(wr1), .Addr(addr1), .Wdata(wdata1),
      .Switches(switches1), .Rdata(rdata1), .Done(done1), .Busy(busy1), .Hex_data(hex_data1),
      .ADDR(sram_addr1), .SRAM_DQ(sram_dq1), .CE(ce1), .UB(ub1), .LB(lb1), .OE(oe1), .WE(we1)
   );

   // SRAM model: writes commit on WE release only after a minimum 2-cycle WE pulse.
   logic [15:0] mem [0:255];
   logic        pl_en = 1'b0;
   logic [7:0]  pl_addr = 8'h00;
   logic [15:0] pl_data = 16'h0000;
   int          we_low_cnt = 0;
   logic [7:0]  wl_addr = 8'h00;
   logic [15:0] wl_data = 16'h0000;

   assign sram_dq  = (!ce && !oe && we) ? mem[sram_addr[7:0]] : 16'hzzzz;
   assign sram_dq1 = (!ce1 && !oe1 && we1) ? {sram_addr1[7:0], 8'hC3} : 16'hzzzz;

   always @(posedge Clk) begin
      if (pl_en) begin
         mem[pl_addr] <= pl_data;
      end else if (!ce && !we) begin
         we_low_cnt <= we_low_cnt + 1;
         wl_addr    <= sram_addr[7:0];
         wl_data    <= sram_dq;
      end else begin
         if (we_low_cnt >= 2) mem[wl_addr] <= wl_data;
         we_low_cnt <= 0;
      end
   end

   task automatic preload(input logic [7:0] a, input logic [15:0] d);
      @(negedge Clk);
      pl_en = 1'b1; pl_addr = a; pl_data = d;
      @(negedge Clk);
      pl_en = 1'b0;
   endtask

   task automatic start_req(input logic w, input logic [15:0] a, input logic [15:0] d);
      @(negedge Clk);
      req = 1'b1; wr = w; addr = a; wdata = d;
      @(posedge Clk);
      #1 req = 1'b0;
   endtask

   task automatic test_reset;
      Reset = 1'b1;
      repeat (2) @(posedge Clk);
      @(negedge Clk);
      n_checks++; if (rdata !== 16'h0000) begin n_fail++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
      n_checks++; if (hex_data !== 16'h0000) begin n_fail++; $display("FAIL rst_hex: got %h expected 0000", hex_data); end
      n_checks++; if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_done_busy: got %b expected 00", {done, busy}); end
      n_checks++; if (sram_addr !== 16'h0000) begin n_fail++; $display("FAIL rst_addr: got %h expected 0000", sram_addr); end
      n_checks++; if ({ce, ub, lb, oe, we} !== 5'b11111) begin n_fail++; $display("FAIL rst_strobes: got %b expected 11111", {ce, ub, lb, oe, we}); end
      n_checks++; if (sram_dq !== 16'hFFFF) begin n_fail++; $display("FAIL rst_dq_released: got %h expected ffff (pulled up)", sram_dq); end
      Reset = 1'b0;
   endtask

   task automatic test_sram_read;
      int oe_lo = 0, ce_lo = 0, we_lo = 0, n_done = 0, done_at = 0;
      start_req(1'b0, 16'h0010, 16'h0000);
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if (!oe && i <= 3) oe_lo++;
         if (!oe && i > 3) oe_lo += 10;
         if (!ce && !ub && !lb) ce_lo++;
         if (!we) we_lo++;
         if (done) begin n_done++; done_at = i; end
         if (i == 1) begin
            n_checks++; if (sram_addr !== 16'h0010) begin n_fail++; $display("FAIL rd_addr: got %h expected 0010", sram_addr); end
         end
         if (i == 3) begin
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy_mid: got %b expected 1", busy); end
         end
         if (i == 5) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_after: got %b expected 0", busy); end
         end
      end
      n_checks++; if (oe_lo != 3) begin n_fail++; $display("FAIL rd_oe_window: got %0d expected 3", oe_lo); end
      n_checks++; if (ce_lo != 3) begin n_fail++; $display("FAIL rd_ce_cycles: got %0d expected 3", ce_lo); end
      n_checks++; if (we_lo != 0) begin n_fail++; $display("FAIL rd_we_low: got %0d expected 0", we_lo); end
      n_checks++; if (n_done != 1 || done_at != 4) begin n_fail++; $display("FAIL rd_done_cycle: got %0d pulses at %0d expected 1 at 4", n_done, done_at); end
      n_checks++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL rd_data: got %h expected 1234", rdata); end
   endtask

   task automatic test_sram_write;
      int we_lo = 0, dq_ok = 0, oe_lo = 0;
      start_req(1'b1, 16'h0020, 16'hBEEF);
      addr = 16'h0030; wdata = 16'h1111; wr = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if (!we && (i == 2 || i == 3)) we_lo++;
         if (!we && !(i == 2 || i == 3)) we_lo += 10;
         if (!oe) oe_lo++;
         if (i == 2 || i == 3) begin
            if (sram_dq === 16'hBEEF) dq_ok++;
         end else begin
            if (sram_dq === 16'hFFFF) dq_ok++;
         end
      end
      n_checks++; if (we_lo != 2) begin n_fail++; $display("FAIL wr_we_window: got %0d expected 2", we_lo); end
      n_checks++; if (oe_lo != 0) begin n_fail++; $display("FAIL wr_oe_low: got %0d expected 0", oe_lo); end
      n_checks++; if (dq_ok != 6) begin n_fail++; $display("FAIL wr_dq_drive: got %0d good cycles expected 6", dq_ok); end
      n_checks++; if (mem[8'h20] !== 16'hBEEF) begin n_fail++; $display("FAIL wr_mem: got %h expected beef", mem[8'h20]); end
      n_checks++; if (mem[8'h30] !== 16'h7777) begin n_fail++; $display("FAIL wr_mem_other: got %h expected 7777", mem[8'h30]); end
      n_checks++; if (rdata !== 16'h1234) begin n_fail++; $display("FAIL wr_rdata_kept: got %h expected 1234", rdata); end
   endtask

   task automatic test_io;
      int strobe_lo = 0, dq_bad = 0, done_at = 0;
      switches = 16'h00A5;
      start_req(1'b0, 16'hFFFF, 16'h0000);
      switches = 16'h00A5;
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if ({ce, ub, lb, oe, we} !== 5'b11111) strobe_lo++;
         if (sram_dq !== 16'hFFFF) dq_bad++;
         if (done) done_at = i;
      end
      n_checks++; if (done_at != 4) begin n_fail++; $display("FAIL io_rd_done_cycle: got %0d expected 4", done_at); end
      n_checks++; if (rdata !== 16'h00A5) begin n_fail++; $display("FAIL io_rd_data: got %h expected 00a5", rdata); end
      n_checks++; if (hex_data !== 16'h0000) begin n_fail++; $display("FAIL io_rd_hex_kept: got %h expected 0000", hex_data); end
      start_req(1'b1, 16'hFFFF, 16'h3C3C);
      for (int i = 1; i <= 6; i++) begin
         @(negedge Clk);
         if ({ce, ub, lb, oe, we} !== 5'b11111) strobe_lo++;
         if (sram_dq !== 16'hFFFF) dq_bad++;
      end
      n_checks++; if (strobe_lo != 0) begin n_fail++; $display("FAIL io_strobes: got %0d low cycles expected 0", strobe_lo); end
      n_checks++; if (dq_bad != 0) begin n_fail++; $display("FAIL io_dq_driven: got %0d driven cycles expected 0", dq_bad); end
      n_checks++; if (hex_data !== 16'h3C3C) begin n_fail++; $display("FAIL io_wr_hex: got %h expected 3c3c", hex_data); end
      n_checks++; if (rdata !== 16'h00A5) begin n_fail++; $display("FAIL io_wr_rdata_kept: got %h expected 00a5", rdata); end
   endtask

   task automatic test_back_to_back;
      int n_done = 0, first_done = 0, second_done = 0;
      @(negedge Clk);
      req = 1'b1; wr = 1'b0; addr = 16'h0010;
      @(posedge Clk);
      for (int i = 1; i <= 10; i++) begin
         @(negedge Clk);
         if (i == 1) addr = 16'h0030;
         if (done) begin
            n_done++;
            if (first_done == 0) first_done = i; else second_done = i;
         end
         if (i == 2) begin
            n_checks++; if (sram_addr !== 16'h0010) begin n_fail++; $display("FAIL b2b_addr_first: got %h expected 0010", sram_addr); end
         end
         if (i == 5) begin
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 0", busy); end
         end
         if (i == 6) begin
            n_checks++; if (sram_addr !== 16'h0030) begin n_fail++; $display("FAIL b2b_addr_second: got %h expected 0030", sram_addr); end
         end
         if (i == 9) req = 1'b0;
      end
      n_checks++; if (n_done != 2 || first_done != 4 || second_done != 9) begin
         n_fail++; $display("FAIL b2b_done_cycles: got %0d pulses at %0d,%0d expected 2 at 4,9", n_done, first_done, second_done);
      end
      n_checks++; if (rdata !== 16'h7777) begin n_fail++; $display("FAIL b2b_rdata: got %h expected 7777", rdata); end
   endtask

   task automatic test_reset_abort;
      int n_done = 0;
      start_req(1'b1, 16'h0020, 16'h4444);
      @(negedge Clk);
      @(negedge Clk);
      n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL abort_we_started: got %b expected 0", we); end
      Reset = 1'b1;
      @(negedge Clk);
      Reset = 1'b0;
      n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL abort_idle: got busy/done %b expected 00", {busy, done}); end
      n_checks++; if ({ce, oe, we} !== 3'b111) begin n_fail++; $display("FAIL abort_strobes: got %b expected 111", {ce, oe, we}); end
      n_checks++; if (sram_dq !== 16'hFFFF) begin n_fail++; $display("FAIL abort_dq: got %h expected ffff (released)", sram_dq); end
      for (int i = 0; i < 5; i++) begin
         @(negedge Clk);
         if (done) n_done++;
      end
      n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", n_done); end
      n_checks++; if (mem[8'h20] !== 16'hBEEF) begin n_fail++; $display("FAIL abort_mem: got %h expected beef", mem[8'h20]); end
   endtask

   task automatic test_wait1;
      int oe_lo = 0, overlap = 0, done_at = 0;
      @(negedge Clk);
      req1 = 1'b1; wr1 = 1'b0; addr1 = 16'h0042;
      @(posedge Clk);
      #1 req1 = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge Clk);
         if (!oe1) oe_lo++;
         if (!oe1 && !we1) overlap++;
         if (done1 && done_at == 0) done_at = i;
      end
      n_checks++; if (done_at != 3) begin n_fail++; $display("FAIL w1_done_cycle: got %0d expected 3", done_at); end
      n_checks++; if (oe_lo != 2) begin n_fail++; $display("FAIL w1_oe_cycles: got %0d expected 2", oe_lo); end
      n_checks++; if (overlap != 0) begin n_fail++; $display("FAIL w1_oe_we_overlap: got %0d expected 0", overlap); end
      n_checks++; if (rdata1 !== 16'h42C3) begin n_fail++; $display("FAIL w1_rdata: got %h expected 42c3", rdata1); end
   endtask

   initial begin
      Reset = 1'b1;
      req = 1'b0; wr = 1'b0; addr = 16'h0000; wdata = 16'h0000; switches = 16'h0000;
      req1 = 1'b0; wr1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000; switches1 = 16'h0000;
      test_reset();
      preload(8'h10, 16'h1234);
      preload(8'h20, 16'h0000);
      preload(8'h30, 16'h7777);
      test_sram_read();
      test_sram_write();
      test_io();
      test_back_to_back();
      test_reset_abort();
      test_wait1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequential memory-access controller that sits directly downstream of the processor datapath's MAR/MDR and drives the external asynchronous SRAM. It accepts one read or write request at a time from the control unit and sequences the active-low SRAM strobes through a fixed setup/access/complete cycle. It returns read data and a one-cycle completion pulse. Address 16'hFFFF is decoded as memory-mapped I/O: reads return the switch inputs, and writes latch the hex-display register.

## Interface
Parameters:
- WAIT_CYCLES, 2, number of cycles the SRAM strobes are held in ACCESS; legal range ≥1.
- IO_ADDR, 16'hFFFF, memory-mapped I/O address.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Req  in  1  access request; sampled only in IDLE.
- Wr  in  1  1 = write, 0 = read; sampled together with Req.
- Addr  in  16  access address from MAR; latched on request acceptance.
- Wdata  in  16  write data from MDR; latched on request acceptance.
- Switches  in  16  I/O read source.
- Rdata  out  16  registered read result; held until the next read completes.
- Done  out  1  one-cycle completion pulse.
- Busy  out  1  high in every state except IDLE.
- Hex_data  out  16  registered I/O display value.
- ADDR  out  16  SRAM address; the latched address.
- SRAM_DQ  inout  16  SRAM data bus; driven only during write ACCESS, otherwise Z.
- CE, UB, LB, OE, WE  out  1 each  SRAM strobes, all active-low.

## Operation
States:
- IDLE → SETUP when Req = 1. On this edge, latch Addr, Wdata and Wr, and set the io flag = (Addr == IO_ADDR).
- SETUP lasts 1 cycle, then → ACCESS. It loads the wait counter with WAIT_CYCLES-1.
- ACCESS counts down and → DONE when the counter reaches 0.
- DONE lasts 1 cycle with Done = 1, then → IDLE.

Strobes for SRAM accesses (io = 0):
- CE, UB and LB are low in SETUP and ACCESS.
- For a read, OE is low in SETUP and ACCESS.
- For a write, WE is low in ACCESS only. SRAM_DQ drives the latched Wdata in ACCESS only.
- All strobes are high in IDLE and DONE. OE and WE are never low in the same cycle.

Data capture:
- SRAM read: Rdata ← SRAM_DQ on the edge leaving ACCESS.
- I/O access (io = 1): all SRAM strobes stay high for the whole transaction, with the same state sequence and latency.
  - I/O read: Rdata ← Switches on the edge leaving ACCESS.
  - I/O write: Hex_data ← latched Wdata on the edge leaving ACCESS.

Boundary rules:
- Req while Busy is ignored. It is not queued.
- Req held high through DONE starts a new transaction only after returning to IDLE, i.e. the cycle after Done.
- A write does not change Rdata.
- A read does not change Hex_data.
- Addr, Wdata and Wr changing mid-transaction have no effect.

Reset (from any state, including mid-transaction) takes effect on the next edge:
- state = IDLE.
- Rdata = 0, Hex_data = 0, Done = 0, Busy = 0, ADDR = 0.
- All strobes high, SRAM_DQ = Z.
- A write is aborted with WE high.

## Timing
- Latency: request accepted at edge k → Done high in cycle k+WAIT_CYCLES+2 → Busy low from edge k+WAIT_CYCLES+3.
  - Default WAIT_CYCLES = 2: Done is seen 4 cycles after the acceptance edge.
- Back-to-back rate: one transaction per WAIT_CYCLES+3 cycles.
- All outputs are registered except SRAM_DQ, which is a tristate driven from a registered enable and registered data.
- SRAM read-data setup requirement: valid by the end of the last ACCESS cycle.

## Structure
- Package mem_ctrl_pkg holds:
  - the state enum (IDLE, SETUP, ACCESS, DONE);
  - IO_ADDR default constant;
  - the counter-width helper, $clog2(WAIT_CYCLES+1).
- The SRAM_DQ driver reuses the existing tri_buffer_16, with Enable = write-ACCESS and In = latched Wdata.
- All other logic stays in a single FSM module.

## Test plan
- Reset, then SRAM read at 16'h0010 with the model returning 16'h1234: OE/CE low for 3 cycles, WE stays high, Done in cycle k+4, Rdata = 16'h1234, Busy drops the next cycle.
- SRAM write of 16'hBEEF to 16'h0020: WE low exactly 2 cycles, SRAM_DQ = 16'hBEEF only during those cycles and Z elsewhere, memory-model readback = 16'hBEEF, Rdata unchanged.
- I/O read at 16'hFFFF with Switches = 16'h00A5: no strobe ever low, Rdata = 16'h00A5 at Done; I/O write of 16'h3C3C sets Hex_data = 16'h3C3C with no strobe low.
- Req held high continuously, with Addr changed mid-transaction: second transaction accepted the cycle after Done, using the address present at its own acceptance edge.
- Reset asserted in the first ACCESS cycle of a write: next cycle is IDLE, WE high, SRAM_DQ = Z, Done never pulses, memory location unmodified.
- WAIT_CYCLES = 1 build: read completes with Done in cycle k+3, and OE is never low simultaneously with WE.
